// File: rtl/dti_apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Optional ACCESS-phase timeout is built in when APB_ARB_TIMEOUT_EN is defined.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif
`ifndef APB_STRB_WIDTH
`define APB_STRB_WIDTH 4
`endif

module dti_apb_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = `APB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = `APB_DATA_WIDTH,
    parameter int STRB_WIDTH     = `APB_STRB_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [NUM_REQ*STRB_WIDTH-1:0]   req_strb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic [ADDR_WIDTH-1:0]           PADDR,
    output logic [DATA_WIDTH-1:0]           PWDATA,
    output logic [STRB_WIDTH-1:0]           PSTRB,
    output logic                            PWRITE,
    output logic                            PSEL,
    output logic                            PENABLE,
    input  logic [DATA_WIDTH-1:0]           PRDATA,
    input  logic                            PREADY,
    input  logic                            PSLVERR
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_e;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0]   cand_t;

    state_e                  state_q;
    idx_t                    rr_ptr_q;
    idx_t                    grant_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic [STRB_WIDTH-1:0]   pstrb_q;
    logic                    pwrite_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [NUM_REQ-1:0]      rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_err_q;

    idx_t                    gnt_idx;
    logic                    gnt_vld;
    cand_t                   cand;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [STRB_WIDTH-1:0]   sel_strb;
    logic                    sel_write;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;

    logic [CNT_W-1:0]        wait_q;
    logic                    to_hit;

    assign to_hit = ({1'b0, wait_q} + (CNT_W+1)'(1))
                    >= (CNT_W+1)'(TIMEOUT_CYCLES);
`else
    logic                    unused_timeout;

    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + cand_t'(k);
            if (cand >= cand_t'(NUM_REQ)) begin
                cand = cand - cand_t'(NUM_REQ);
            end
            if (!gnt_vld && req_valid[cand[IDX_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (PRESETn && (state_q == IDLE) && gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign sel_addr  = req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_strb  = req_strb[gnt_idx*STRB_WIDTH +: STRB_WIDTH];
    assign sel_write = req_write[gnt_idx];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= idx_t'(NUM_REQ-1);
            grant_q     <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            wait_q      <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (gnt_vld) begin
                        paddr_q   <= sel_addr;
                        pwrite_q  <= sel_write;
                        pwdata_q  <= sel_wdata;
                        pstrb_q   <= sel_write ? sel_strb : '0;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        rr_ptr_q  <= gnt_idx;
                        grant_q   <= gnt_idx;
                        state_q   <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                    wait_q    <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        psel_q               <= 1'b0;
                        penable_q            <= 1'b0;
                        pstrb_q              <= '0;
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_rdata_q          <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q            <= PSLVERR;
                        state_q              <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (to_hit) begin
                        psel_q               <= 1'b0;
                        penable_q            <= 1'b0;
                        pstrb_q              <= '0;
                        rsp_valid_q[grant_q] <= 1'b1;
                        rsp_rdata_q          <= '0;
                        rsp_err_q            <= 1'b1;
                        state_q              <= IDLE;
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dti_apb_master_arbiter.sv
// Bench for dti_apb_master_arbiter: transaction-level model plus
// directed literal checks and randomized traffic.
`timescale 1ns/1ps
module tb_dti_apb_master_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 5;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [N-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [DW-1:0]   rsp_rdata, PWDATA, PRDATA;
    logic            rsp_err, PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
    logic [AW-1:0]   PADDR;
    logic [SW-1:0]   PSTRB;

    int checks = 0;
    int errors = 0;

    always #5 PCLK = ~PCLK;

    dti_apb_master_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transfer, round-robin by last winner.
    bit            m_busy;
    int            m_phase, m_owner, m_last, m_wait, pick;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_strb;
    logic          m_write, m_err;
    logic [N-1:0]  m_rsp;
    int            acc_log[$];

    function automatic int rr_pick(logic [N-1:0] v, int last);
        for (int k = 1; k <= N; k++) begin
            int i = (last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r = '0;
        if (PRESETn && !m_busy && pick >= 0) r[pick] = 1'b1;
        return r;
    endfunction

    always_comb pick = rr_pick(req_valid, m_last);

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            m_busy <= 0; m_phase <= 0; m_owner <= 0; m_last <= N-1;
            m_wait <= 0; m_addr <= '0; m_wdata <= '0; m_write <= 0;
            m_strb <= '0; m_rsp <= '0; m_rdata <= '0; m_err <= 0;
        end else begin
            m_rsp <= '0;
            if (!m_busy) begin
                if (pick >= 0) begin
                    m_busy  <= 1; m_phase <= 1;
                    m_owner <= pick; m_last <= pick;
                    m_addr  <= req_addr[pick*AW +: AW];
                    m_wdata <= req_wdata[pick*DW +: DW];
                    m_write <= req_write[pick];
                    m_strb  <= req_write[pick] ? req_strb[pick*SW +: SW] : '0;
                    acc_log.push_back(pick);
                end
            end else if (m_phase == 1) begin
                m_phase <= 2; m_wait <= 0;
            end else if (PREADY) begin
                m_busy <= 0; m_phase <= 0; m_rsp[m_owner] <= 1'b1;
                m_rdata <= m_write ? '0 : PRDATA; m_err <= PSLVERR;
            end
`ifdef APB_ARB_TIMEOUT_EN
            else if (m_wait + 1 >= TO) begin
                m_busy <= 0; m_phase <= 0; m_rsp[m_owner] <= 1'b1;
                m_rdata <= '0; m_err <= 1'b1;
            end else begin
                m_wait <= m_wait + 1;
            end
`endif
        end
    end

    always @(negedge PCLK) begin
        chk("req_ready", req_ready, exp_ready());
        chk("PSEL", PSEL, m_busy);
        chk("PENABLE", PENABLE, m_busy && m_phase == 2);
        chk("PADDR", PADDR, m_addr);
        chk("PWDATA", PWDATA, m_wdata);
        chk("PWRITE", PWRITE, m_write);
        chk("PSTRB", PSTRB, m_busy ? m_strb : '0);
        chk("rsp_valid", rsp_valid, m_rsp);
        if (|m_rsp) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, m_err);
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_req(int i, logic w, logic [AW-1:0] a,
                           logic [DW-1:0] d, logic [SW-1:0] s);
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW] = s;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 4'hF; req_write = '0; req_addr = '0;
        req_wdata = '0; req_strb = '0; PRDATA = '0;
        PREADY = 1'b1; PSLVERR = 1'b0;

        @(negedge PCLK);
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_penable", PENABLE, 1'b0);
        chk("rst_rsp", rsp_valid, 4'b0000);
        tick(); tick();
        PRESETn = 1'b1;
        @(negedge PCLK);
        chk("post_rst_ready", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (4) tick();

        set_req(2, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF);
        req_valid = 4'b0100;
        @(negedge PCLK);
        chk("w_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge PCLK);
        chk("w_setup_psel", PSEL, 1'b1);
        chk("w_setup_pen", PENABLE, 1'b0);
        chk("w_paddr", PADDR, 32'h10);
        chk("w_pstrb", PSTRB, 4'hF);
        tick();
        @(negedge PCLK);
        chk("w_access_psel", PSEL, 1'b1);
        chk("w_access_pen", PENABLE, 1'b1);
        tick();
        @(negedge PCLK);
        chk("w_rsp", rsp_valid, 4'b0100);
        chk("w_err", rsp_err, 1'b0);
        chk("w_done_psel", PSEL, 1'b0);
        tick();

        set_req(0, 1'b0, 32'h04, 32'hDEAD_BEEF, 4'hF);
        req_valid = 4'b0001;
        PREADY = 1'b0;
        tick();
        req_valid = '0;
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            chk("r_wait_pen", PENABLE, 1'b1);
            chk("r_wait_paddr", PADDR, 32'h04);
            chk("r_wait_pstrb", PSTRB, 4'h0);
            chk("r_wait_rsp", rsp_valid, 4'b0000);
            tick();
        end
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        tick();
        @(negedge PCLK);
        chk("r_rsp", rsp_valid, 4'b0001);
        chk("r_rdata", rsp_rdata, 32'h1234_5678);
        tick();

        set_req(1, 1'b1, 32'h20, 32'h0BAD_0000, 4'h3);
        req_valid = 4'b0010;
        PSLVERR = 1'b1;
        tick();
        req_valid = '0;
        tick(); tick();
        @(negedge PCLK);
        chk("e_rsp", rsp_valid, 4'b0010);
        chk("e_err", rsp_err, 1'b1);
        tick();
        PSLVERR = 1'b0;

        set_req(3, 1'b0, 32'h30, 32'h0, 4'h0);
        req_valid = 4'b1000;
        PREADY = 1'b0;
        tick();
        req_valid = '0;
        tick(); tick();
        #2 PRESETn = 1'b0;
        @(negedge PCLK);
        chk("ar_psel", PSEL, 1'b0);
        chk("ar_pen", PENABLE, 1'b0);
        tick();
        PRESETn = 1'b1;
        PREADY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            chk("ar_no_rsp", rsp_valid, 4'b0000);
            tick();
        end
        req_valid = 4'b1000;
        @(negedge PCLK);
        chk("ar_idle_ready", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        repeat (4) tick();

        acc_log.delete();
        req_valid = 4'hF;
        for (int c = 0; c < 60 && acc_log.size() < 8; c++) tick();
        req_valid = '0;
        chk("fair_count", acc_log.size(), 8);
        if (acc_log.size() >= 8)
            for (int i = 0; i < 8; i++) chk("fair_order", acc_log[i], i % 4);
        repeat (4) tick();

        set_req(1, 1'b0, 32'h40, 32'h0, 4'h0);
        req_valid = 4'b0010;
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
        tick();
        req_valid = '0;
        tick();
`ifdef APB_ARB_TIMEOUT_EN
        for (int c = 0; c < 4; c++) begin
            @(negedge PCLK);
            chk("to_pending", rsp_valid, 4'b0000);
            tick();
        end
        tick();
        @(negedge PCLK);
        chk("to_rsp", rsp_valid, 4'b0010);
        chk("to_err", rsp_err, 1'b1);
        chk("to_rdata", rsp_rdata, 32'h0);
`else
        repeat (20) tick();
        @(negedge PCLK);
        chk("hang_psel", PSEL, 1'b1);
        chk("hang_pen", PENABLE, 1'b1);
`endif
        PREADY = 1'b1;
        repeat (3) tick();

        for (int c = 0; c < 3000; c++) begin
            PRESETn = ($urandom_range(0, 399) != 0);
            PREADY  = ($urandom_range(0, 2) != 0);
            PSLVERR = $urandom_range(0, 1);
            PRDATA  = $urandom;
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom,
                        SW'($urandom_range(0, 15)));
            tick();
        end
        PRESETn = 1'b1;
        req_valid = '0;
        PREADY = 1'b1;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
